// File: rtl/ps2_pkg.sv
// Shared types and frame helpers for the PS/2 device-side transmitter.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_HI,
    FRAME_LO,
    GAP,
    INHIBIT
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Line value of frame bit idx: start 0, D0..D7, odd parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [FRAME_BITS-1:0] f;
    f = {1'b1, odd_parity(b), b, 1'b0};
    return (idx < 4'(FRAME_BITS)) ? f[idx] : 1'b1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two FIFO with extra-MSB pointers; head byte visible combinationally.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign level   = wptr - rptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_tx_fifo.sv
// Buffered PS/2 device transmitter with host-inhibit abort and retransmit.
module ps2_tx_fifo
  import ps2_pkg::*;
#(
  parameter int HALF_CYCLES = 20,
  parameter int GAP_CYCLES  = 40,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   ps2_clk_in,
  output logic                   ps2_clk_oe,
  output logic                   ps2_data_oe,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   abort_pulse
);

  localparam int CMAX = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  ps2_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_n;
  logic          sync1, sync2;
  logic          oe_d1, oe_d2;
  logic          clk_low_s, inhibit, abortable;
  logic          pop, push, full, empty;
  logic [7:0]    head;
  logic          busy_n, clk_oe_n, data_oe_n, abort_n;

  assign push     = s_tvalid && s_tready;
  assign s_tready = !full;

  byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s_tdata),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The synchronised line lags two cycles, so it is compared against the
  // clock enable delayed by the same two cycles; otherwise our own low
  // phase would read back as a host inhibit right after release.
  assign clk_low_s = !sync2;
  assign inhibit   = clk_low_s && !oe_d2;
  assign abortable = inhibit && (bit_idx != LAST_BIT);

  // Next-state, counters, FIFO pop and registered-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    pop     = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (inhibit) begin
          state_n = INHIBIT;
        end else if (!empty) begin
          state_n = FRAME_HI;
          bit_n   = '0;
        end
      end
      FRAME_HI, FRAME_LO: begin
        // Samples taken while the clock was released arrive during the
        // following low phase, hence the check in both halves.
        if (abortable) begin
          state_n = INHIBIT;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (state == FRAME_HI) begin
            state_n = FRAME_LO;
          end else if (bit_idx == LAST_BIT) begin
            pop     = 1'b1;
            state_n = GAP;
          end else begin
            bit_n   = bit_idx + 4'd1;
            state_n = FRAME_HI;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP, INHIBIT: begin
        if (inhibit) begin
          state_n = INHIBIT;
          cnt_n   = '0;
        end else if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n    = (state_n == FRAME_HI) || (state_n == FRAME_LO);
    clk_oe_n  = (state_n == FRAME_LO);
    data_oe_n = busy_n && !frame_bit(head, bit_n);
  end

  // State, synchroniser and glitch-free registered line enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      oe_d1       <= 1'b0;
      oe_d2       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      sync1       <= ps2_clk_in;
      sync2       <= sync1;
      oe_d1       <= ps2_clk_oe;
      oe_d2       <= oe_d1;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      abort_pulse <= abort_n;
    end
  end

endmodule

// File: tb/tb_ps2_tx_fifo.sv
// Self-checking bench: decodes frames off the line enables and compares
// them with a queue of accepted bytes.
module tb_ps2_tx_fifo;

  localparam int HALF  = 2;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       host_low = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic [2:0] level;
  logic       abort_pulse;

  always #5 clk = ~clk;

  assign ps2_clk_in = host_low ? 1'b0 : ~ps2_clk_oe;

  ps2_tx_fifo #(.HALF_CYCLES(HALF), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .level       (level),
    .abort_pulse (abort_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] exp_q[$];
  int         exp_level = 0;

  // Line monitor / frame decoder
  logic [7:0]  rx_q[$];
  logic        rx_ok_q[$];
  int          len_q[$];
  int          cyc = 0;
  int          mon_nbits = 0;
  logic [10:0] bits = '0;
  int          lo_w = 0;
  logic        widths_ok = 1'b1;
  int          busy_len = 0;
  int          abort_cnt = 0;
  int          busy_rise_cyc = 0;
  int          idle_run = 0;
  int          min_gap = 1000;
  logic        seen_frame = 1'b0;
  logic        prev_oe = 1'b0;
  logic        prev_busy = 1'b0;
  logic [7:0]  dbyte;
  logic        par_exp;

  always @(negedge clk) begin
    cyc++;
    if (abort_pulse) abort_cnt++;
    if (!rst_n) begin
      mon_nbits  = 0;
      widths_ok  = 1'b1;
      lo_w       = 0;
      busy_len   = 0;
      idle_run   = 0;
      seen_frame = 1'b0;
      prev_oe    = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (ps2_clk_oe) begin
        if (!prev_oe) begin
          if (mon_nbits < 11) bits[mon_nbits] = ~ps2_data_oe;
          mon_nbits++;
          lo_w = 0;
        end
        lo_w++;
      end else if (prev_oe && lo_w != HALF) begin
        widths_ok = 1'b0;
      end
      if (busy) begin
        if (!prev_busy) begin
          busy_rise_cyc = cyc;
          if (seen_frame && idle_run < min_gap) min_gap = idle_run;
          busy_len = 0;
        end
        busy_len++;
      end else if (prev_busy) begin
        if (!abort_pulse) begin
          dbyte   = bits[8:1];
          par_exp = (($countones(dbyte) % 2) == 0);
          rx_q.push_back(dbyte);
          rx_ok_q.push_back(mon_nbits == 11 && widths_ok && bits[0] == 1'b0 &&
                            bits[10] == 1'b1 && bits[9] == par_exp);
          len_q.push_back(busy_len);
          exp_level--;
          seen_frame = 1'b1;
        end
        mon_nbits = 0;
        widths_ok = 1'b1;
        idle_run  = 0;
      end
      if (!busy && !ps2_clk_oe && !ps2_data_oe) idle_run++;
      prev_oe   = ps2_clk_oe;
      prev_busy = busy;
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (exp_level >= DEPTH && n < 2000) begin
      chk("tready_full", 32'(s_tready), 32'(0));
      @(negedge clk); #1;
      n++;
    end
    chk("tready", 32'(s_tready), 32'(1));
    s_tdata  = b;
    s_tvalid = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    exp_level++;
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_level != 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'(1));
  endtask

  task automatic wait_bit_hi(input int k);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(mon_nbits == k && busy && !ps2_clk_oe) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bit_wait_timeout", 32'(n < 500), 32'(1));
  endtask

  task automatic check_frames();
    logic [7:0] e, r;
    logic       ok;
    int         l;
    while (exp_q.size() > 0) begin
      if (rx_q.size() == 0) begin
        chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        break;
      end
      e  = exp_q.pop_front();
      r  = rx_q.pop_front();
      ok = rx_ok_q.pop_front();
      l  = len_q.pop_front();
      chk("rx_byte", 32'(r), 32'(e));
      chk("rx_frame_ok", 32'(ok), 32'(1));
      chk("frame_len", 32'(l), 32'(22 * HALF));
    end
    chk("rx_extra", 32'(rx_q.size()), 32'(0));
  endtask

  initial begin
    int a0, r0, rel_cyc, n;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'(0));
    chk("rst_data_oe", 32'(ps2_data_oe), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_abort", 32'(abort_pulse), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_tready", 32'(s_tready), 32'(1));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 0xFF, start-bit latency, frame shape and length
    push(8'hFF);
    chk("t1_level_after_push", 32'(level), 32'(1));
    chk("t1_no_start_yet", 32'(ps2_data_oe), 32'(0));
    @(posedge clk); #1;
    chk("t1_start_bit", 32'(ps2_data_oe), 32'(1));
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_clk_released", 32'(ps2_clk_oe), 32'(0));
    wait_drain(300);
    chk("t1_level_end", 32'(level), 32'(0));
    check_frames();

    // 2: parity of 0x00 / 0x01, order, gap
    min_gap = 1000;
    push(8'h00);
    push(8'h01);
    wait_drain(400);
    check_frames();
    chk("t2_gap", 32'(min_gap >= GAP && min_gap <= GAP + 2), 32'(1));

    // 3: back-to-back overflow
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h10 + i));
      if (i == 3) begin
        chk("t3_level_full", 32'(level), 32'(DEPTH));
        chk("t3_tready_low", 32'(s_tready), 32'(0));
      end
    end
    wait_drain(1000);
    check_frames();

    // 4: inhibit during bit 3 of 0xA5
    a0 = abort_cnt;
    push(8'hA5);
    wait_bit_hi(3);
    host_low = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_abort_busy", 32'(busy), 32'(0));
    chk("t4_abort_clk_oe", 32'(ps2_clk_oe), 32'(0));
    chk("t4_abort_data_oe", 32'(ps2_data_oe), 32'(0));
    chk("t4_level_kept", 32'(level), 32'(1));
    repeat (10) @(negedge clk);
    #1;
    chk("t4_abort_count", 32'(abort_cnt - a0), 32'(1));
    chk("t4_held_off", 32'(busy), 32'(0));
    rel_cyc = cyc;
    host_low = 1'b0;
    wait_drain(400);
    chk("t4_resend_delay", 32'(busy_rise_cyc - rel_cyc >= GAP), 32'(1));
    check_frames();

    // 5: inhibit during stop bit is ignored, then held in inhibit
    a0 = abort_cnt;
    push(8'h3C);
    wait_bit_hi(10);
    host_low = 1'b1;
    wait_drain(200);
    chk("t5_no_abort", 32'(abort_cnt), 32'(a0));
    chk("t5_level_popped", 32'(level), 32'(0));
    check_frames();
    push(8'h5A);
    r0 = busy_rise_cyc;
    repeat (30) @(negedge clk);
    #1;
    chk("t5_inhibit_hold", 32'(busy_rise_cyc), 32'(r0));
    chk("t5_level_waiting", 32'(level), 32'(1));
    host_low = 1'b0;
    wait_drain(400);
    check_frames();

    // 6: asynchronous reset mid-frame
    push(8'h11);
    push(8'h22);
    n = 0;
    @(negedge clk); #1;
    while (!(busy && ps2_clk_oe && mon_nbits >= 4) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_wait_timeout", 32'(n < 500), 32'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("t6_clk_oe", 32'(ps2_clk_oe), 32'(0));
    chk("t6_data_oe", 32'(ps2_data_oe), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_level", 32'(level), 32'(0));
    chk("t6_tready", 32'(s_tready), 32'(1));
    exp_q.delete();
    exp_level = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    rx_q.delete();
    rx_ok_q.delete();
    len_q.delete();
    r0 = busy_rise_cyc;
    repeat (60) @(negedge clk);
    #1;
    chk("t6_silent", 32'(busy_rise_cyc), 32'(r0));
    chk("t6_level_after", 32'(level), 32'(0));

    // Randomised bytes with random spacing
    repeat (12) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      push(8'($urandom));
    end
    wait_drain(5000);
    check_frames();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
